// File: rtl/multi_acc_pkg.sv
// Shared definitions for the multi-channel gated accumulator.
//   - default parameter values
//   - 1-bit FSM state encoding (ST_IDLE=0, ST_ACCUM=1)
//   - sext(): sign-extends the low in_w bits of a value to SEXT_MAX_W bits
package multi_acc_pkg;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 64;
  localparam int DEF_CNT_W = 32;

  // Widest accumulator the sign-extension helper supports.
  localparam int SEXT_MAX_W = 128;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Shift the sample's sign bit up to the MSB, then arithmetic-shift it back.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] val,
                                                  input int in_w);
    logic signed [SEXT_MAX_W-1:0] t;
    t = $signed(val << (SEXT_MAX_W - in_w));
    return t >>> (SEXT_MAX_W - in_w);
  endfunction

endpackage

// File: rtl/acc_channel.sv
// One accumulator lane plus its hold register.
// Optional build macro: ACC_SATURATE_EN (clamp instead of wrap, adds acc_sat).
// Ports:
//   aclk, rst       clock, async active-low reset
//   load            start of window: acc <= sext(in_sample)
//   add             inside window:   acc <= acc + sext(in_sample)
//   latch           window end:      out_total <= acc
//   in_sample       signed sample, IN_W bits
//   out_total       held signed total, ACC_W bits
//   acc_sat         (ACC_SATURATE_EN only) lane clamped during the held window
module acc_channel
  import multi_acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             load,
  input  logic             add,
  input  logic             latch,
  input  logic [IN_W-1:0]  in_sample,
  output logic [ACC_W-1:0] out_total
`ifdef ACC_SATURATE_EN
  ,
  output logic             acc_sat
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sample_ext;

  assign sample_ext = ACC_W'(sext(SEXT_MAX_W'(in_sample), IN_W));

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] sum;
  logic             ovf_pos;
  logic             ovf_neg;
  logic             sat_seen;

  assign sum = acc + sample_ext;
  // Overflow only when both operands share a sign the result does not.
  assign ovf_pos = !acc[ACC_W-1] && !sample_ext[ACC_W-1] &&  sum[ACC_W-1];
  assign ovf_neg =  acc[ACC_W-1] &&  sample_ext[ACC_W-1] && !sum[ACC_W-1];

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      sat_seen <= 1'b0;
    end else if (load) begin
      // ACC_W >= IN_W, so loading a single sample never clamps.
      acc      <= sample_ext;
      sat_seen <= 1'b0;
    end else if (add) begin
      if (ovf_pos) begin
        acc      <= ACC_MAX;
        sat_seen <= 1'b1;
      end else if (ovf_neg) begin
        acc      <= ACC_MIN;
        sat_seen <= 1'b1;
      end else begin
        acc <= sum;
      end
    end
  end

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      out_total <= '0;
      acc_sat   <= 1'b0;
    end else if (latch) begin
      out_total <= acc;
      acc_sat   <= sat_seen;
    end
  end
`else
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= sample_ext;
    end else if (add) begin
      acc <= acc + sample_ext;
    end
  end

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      out_total <= '0;
    end else if (latch) begin
      out_total <= acc;
    end
  end
`endif

endmodule

// File: rtl/multi_channel_accumulator.sv
// Sums N_CH signed sample streams over each enable-high window, latches the
// totals and sample count, and offers them with a valid/ready handshake.
// Optional build macro: ACC_SATURATE_EN (clamping lanes, adds acc_sat port).
// Ports:
//   aclk, rst   clock, async active-low reset
//   enable      window gate
//   in_data     packed samples, channel k at [k*IN_W +: IN_W]
//   out_data    packed held totals, channel k at [k*ACC_W +: ACC_W]
//   out_count   samples in the held window
//   out_valid   held result pending; out_ready accepts it
//   overrun     sticky, a pending result was overwritten; clr_flags clears
//   count_sat   held window's counter reached its maximum
//   acc_sat     (ACC_SATURATE_EN only) per-channel clamp flag of held window
//
// state    | meaning
// ST_IDLE  | no window open; enable=1 loads the first sample
// ST_ACCUM | window open; enable=1 adds, enable=0 latches result
module multi_channel_accumulator
  import multi_acc_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,   // must be >= IN_W
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_CH*IN_W-1:0]  in_data,
  output logic [N_CH*ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  count_sat,
  input  logic                  clr_flags
`ifdef ACC_SATURATE_EN
  ,
  output logic [N_CH-1:0]       acc_sat
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             ld;
  logic             add;
  logic             latch;

  assign ld    = (state == ST_IDLE)  &&  enable;
  assign add   = (state == ST_ACCUM) &&  enable;
  assign latch = (state == ST_ACCUM) && !enable;

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      count_sat <= 1'b0;
    end else begin
      // Acceptance first so a coinciding window end re-asserts valid below.
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Clear first so a coinciding overrun event wins.
      if (clr_flags) overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            count <= CNT_W'(1);
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (enable) begin
            if (count != CNT_MAX) count <= count + 1'b1;
          end else begin
            out_count <= count;
            count_sat <= (count == CNT_MAX);
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    acc_channel #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_ch (
      .aclk      (aclk),
      .rst       (rst),
      .load      (ld),
      .add       (add),
      .latch     (latch),
      .in_sample (in_data[k*IN_W +: IN_W]),
      .out_total (out_data[k*ACC_W +: ACC_W])
`ifdef ACC_SATURATE_EN
      ,
      .acc_sat   (acc_sat[k])
`endif
    );
  end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
module tb_multi_channel_accumulator;

  // Main instance: default widths.
  logic         aclk;
  logic         rst;
  logic         enable;
  logic [63:0]  in_data;
  logic [127:0] out_data;
  logic [31:0]  out_count;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;
  logic         count_sat;
  logic         clr_flags;
`ifdef ACC_SATURATE_EN
  logic [1:0]   acc_sat;
`endif

  // Narrow instance: IN_W=ACC_W=8, CNT_W=3 to reach wrap/clamp and counter max.
  logic         s_enable;
  logic [15:0]  s_in_data;
  logic [15:0]  s_out_data;
  logic [2:0]   s_out_count;
  logic         s_out_valid;
  logic         s_out_ready;
  logic         s_overrun;
  logic         s_count_sat;
  logic         s_clr_flags;
`ifdef ACC_SATURATE_EN
  logic [1:0]   s_acc_sat;
`endif

  int checks   = 0;
  int failures = 0;

  multi_channel_accumulator dut (
    .aclk      (aclk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .count_sat (count_sat),
    .clr_flags (clr_flags)
`ifdef ACC_SATURATE_EN
    ,
    .acc_sat   (acc_sat)
`endif
  );

  multi_channel_accumulator #(
    .N_CH(2), .IN_W(8), .ACC_W(8), .CNT_W(3)
  ) dut_s (
    .aclk      (aclk),
    .rst       (rst),
    .enable    (s_enable),
    .in_data   (s_in_data),
    .out_data  (s_out_data),
    .out_count (s_out_count),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .overrun   (s_overrun),
    .count_sat (s_count_sat),
    .clr_flags (s_clr_flags)
`ifdef ACC_SATURATE_EN
    ,
    .acc_sat   (s_acc_sat)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  // ---------------- main-instance reference model ----------------
  int     q0[$];
  int     q1[$];
  longint exp0;
  longint exp1;
  int     exp_cnt;
  logic   valid_before_end;

  // Drives q0/q1 as one window, then one enable-low end cycle.
  // Expected totals are the plain 64-bit two's-complement sums.
  task automatic drive_main(input bit ack_first, input bit ack_end);
    exp0    = 0;
    exp1    = 0;
    exp_cnt = q0.size();
    for (int i = 0; i < q0.size(); i++) begin
      enable    = 1'b1;
      in_data   = {q1[i], q0[i]};
      out_ready = (i == 0) ? ack_first : 1'b0;
      exp0 += longint'(q0[i]);
      exp1 += longint'(q1[i]);
      step();
    end
    valid_before_end = out_valid;
    enable    = 1'b0;
    in_data   = {$urandom, $urandom};
    out_ready = ack_end;
    step();
    out_ready = 1'b0;
  endtask

  task automatic accept_main;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- narrow-instance reference model ----------------
  int sq0[$];
  int sq1[$];

  // Reference for one 8-bit lane: wrap modulo 256 or clamp to [-128,127].
  task automatic model_small(input int q[$], input bit sat, output int res, output bit clamped);
    int t;
    res     = 0;
    clamped = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      t = (i == 0) ? q[i] : res + q[i];
      if (sat) begin
        if (t > 127)  begin t = 127;  clamped = 1'b1; end
        if (t < -128) begin t = -128; clamped = 1'b1; end
      end else begin
        t = t & 255;
        if (t > 127) t = t - 256;
      end
      res = t;
    end
  endtask

  task automatic drive_small;
    for (int i = 0; i < sq0.size(); i++) begin
      s_enable  = 1'b1;
      s_in_data = {8'(sq1[i]), 8'(sq0[i])};
      step();
    end
    s_enable  = 1'b0;
    s_in_data = 16'($urandom);
    step();
  endtask

  task automatic accept_small;
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
  endtask

  task automatic check_small(input string name);
    int r0, r1, ecnt;
    bit c0, c1, sat_mode;
`ifdef ACC_SATURATE_EN
    sat_mode = 1'b1;
`else
    sat_mode = 1'b0;
`endif
    model_small(sq0, sat_mode, r0, c0);
    model_small(sq1, sat_mode, r1, c1);
    ecnt = (sq0.size() > 7) ? 7 : sq0.size();
    checks += 5;
    if (s_out_data[7:0] !== 8'(r0)) begin
      failures++; $display("FAIL %s_ch0 got=%0d exp=%0d", name, $signed(s_out_data[7:0]), r0);
    end
    if (s_out_data[15:8] !== 8'(r1)) begin
      failures++; $display("FAIL %s_ch1 got=%0d exp=%0d", name, $signed(s_out_data[15:8]), r1);
    end
    if (s_out_count !== 3'(ecnt)) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", name, s_out_count, ecnt);
    end
    if (s_count_sat !== (sq0.size() >= 7)) begin
      failures++; $display("FAIL %s_count_sat got=%0b exp=%0b", name, s_count_sat, sq0.size() >= 7);
    end
    if (s_out_valid !== 1'b1) begin
      failures++; $display("FAIL %s_valid got=%0b exp=1", name, s_out_valid);
    end
`ifdef ACC_SATURATE_EN
    checks++;
    if (s_acc_sat !== {c1, c0}) begin
      failures++; $display("FAIL %s_acc_sat got=%b exp=%b", name, s_acc_sat, {c1, c0});
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0; enable = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
    s_enable = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_clr_flags = 1'b0;
    repeat (3) step();
    checks += 6;
    if (out_data !== '0)   begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    if (out_count !== '0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    if (overrun !== 1'b0)  begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    if (count_sat !== 1'b0) begin failures++; $display("FAIL reset_count_sat got=%0b exp=0", count_sat); end
    if (s_out_valid !== 1'b0 || s_out_data !== '0)
      begin failures++; $display("FAIL reset_small got=%0b/%h exp=0/0", s_out_valid, s_out_data); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic;
    q0 = '{1, 2, 3, 4};
    q1 = '{-1, -1, -1, -1};
    drive_main(1'b0, 1'b0);
    checks += 6;
    if (valid_before_end !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", valid_before_end); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    if (out_data[63:0] !== 64'd10) begin failures++; $display("FAIL basic_ch0 got=%0d exp=10", $signed(out_data[63:0])); end
    if (out_data[127:64] !== exp1) begin failures++; $display("FAIL basic_ch1 got=%0d exp=%0d", $signed(out_data[127:64]), exp1); end
    if (out_count !== 32'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", out_count); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%0b exp=0", overrun); end
    accept_main();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_accept got=%0b exp=0", out_valid); end
  endtask

  task automatic test_boundary;
    q0 = '{32'h7FFF_FFFF};
    q1 = '{int'($urandom)};
    drive_main(1'b0, 1'b0);
    checks += 3;
    if (out_data[63:0] !== 64'h0000_0000_7FFF_FFFF) begin failures++; $display("FAIL single_ch0 got=%h exp=000000007fffffff", out_data[63:0]); end
    if (out_data[127:64] !== exp1) begin failures++; $display("FAIL single_ch1 got=%h exp=%h", out_data[127:64], exp1); end
    if (out_count !== 32'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", out_count); end
    // back-to-back: next window starts right after the end cycle
    q0 = '{-5, -5, -5};
    q1 = '{int'($urandom), int'($urandom), int'($urandom)};
    drive_main(1'b1, 1'b0);
    checks += 5;
    if (out_data[63:0] !== 64'hFFFF_FFFF_FFFF_FFF1) begin failures++; $display("FAIL b2b_ch0 got=%0d exp=-15", $signed(out_data[63:0])); end
    if (out_data[127:64] !== exp1) begin failures++; $display("FAIL b2b_ch1 got=%h exp=%h", out_data[127:64], exp1); end
    if (out_count !== 32'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", out_count); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", out_valid); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
    accept_main();
  endtask

  task automatic test_overrun;
    q0 = '{1, 2, 3}; q1 = '{0, 0, 0};
    drive_main(1'b0, 1'b0);
    q0 = '{4, 5};    q1 = '{7, 7};
    drive_main(1'b0, 1'b0);
    checks += 4;
    if (out_data[63:0] !== 64'd9) begin failures++; $display("FAIL ovr_ch0 got=%0d exp=9", $signed(out_data[63:0])); end
    if (out_count !== 32'd2) begin failures++; $display("FAIL ovr_count got=%0d exp=2", out_count); end
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%0b exp=1", out_valid); end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks += 2;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold_valid got=%0b exp=1", out_valid); end
    accept_main();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept got=%0b exp=0", out_valid); end
  endtask

  task automatic test_coincident;
    q0 = '{7}; q1 = '{8};
    drive_main(1'b0, 1'b0);
    q0 = '{1, 1}; q1 = '{-3, 2};
    drive_main(1'b0, 1'b1);
    checks += 4;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL coin_valid got=%0b exp=1", out_valid); end
    if (out_data[63:0] !== 64'd2) begin failures++; $display("FAIL coin_ch0 got=%0d exp=2", $signed(out_data[63:0])); end
    if (out_data[127:64] !== exp1) begin failures++; $display("FAIL coin_ch1 got=%0d exp=%0d", $signed(out_data[127:64]), exp1); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL coin_overrun got=%0b exp=0", overrun); end
    accept_main();
  endtask

  task automatic test_reset_mid;
    // leave a pending result so the reset has something to clear
    q0 = '{11}; q1 = '{12};
    drive_main(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      enable  = 1'b1;
      in_data = {$urandom, $urandom};
      step();
    end
    rst = 1'b0;
    #2;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL rmid_data got=%h exp=0", out_data); end
    if (out_count !== '0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", out_count); end
    if (count_sat !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%0b/%0b exp=0/0", count_sat, overrun); end
    enable = 1'b0;
    rst    = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_result got=%0b exp=0", out_valid); end
    q0 = '{int'($urandom), int'($urandom)};
    q1 = '{int'($urandom), int'($urandom)};
    drive_main(1'b0, 1'b0);
    checks += 3;
    if (out_count !== 32'd2) begin failures++; $display("FAIL rmid_next_count got=%0d exp=2", out_count); end
    if (out_data[63:0] !== exp0) begin failures++; $display("FAIL rmid_next_ch0 got=%h exp=%h", out_data[63:0], exp0); end
    if (out_data[127:64] !== exp1) begin failures++; $display("FAIL rmid_next_ch1 got=%h exp=%h", out_data[127:64], exp1); end
    accept_main();
  endtask

  task automatic test_random;
    bit exp_valid, exp_ovr, ack_end;
    int k;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    for (int w = 0; w < 20; w++) begin
      k = $urandom_range(1, 10);
      q0.delete(); q1.delete();
      for (int i = 0; i < k; i++) begin
        q0.push_back(int'($urandom));
        q1.push_back(int'($urandom));
      end
      ack_end = 1'($urandom);
      drive_main(1'b0, ack_end);
      if (exp_valid && !ack_end) exp_ovr = 1'b1;
      exp_valid = 1'b1;
      checks += 5;
      if (out_data[63:0] !== exp0) begin failures++; $display("FAIL rnd%0d_ch0 got=%h exp=%h", w, out_data[63:0], exp0); end
      if (out_data[127:64] !== exp1) begin failures++; $display("FAIL rnd%0d_ch1 got=%h exp=%h", w, out_data[127:64], exp1); end
      if (out_count !== 32'(exp_cnt)) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", w, out_count, exp_cnt); end
      if (out_valid !== exp_valid) begin failures++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", w, out_valid, exp_valid); end
      if (overrun !== exp_ovr) begin failures++; $display("FAIL rnd%0d_overrun got=%0b exp=%0b", w, overrun, exp_ovr); end
`ifdef ACC_SATURATE_EN
      checks++;
      if (acc_sat !== 2'b00) begin failures++; $display("FAIL rnd%0d_acc_sat got=%b exp=00", w, acc_sat); end
`endif
      if ($urandom_range(0, 1) == 1) begin
        accept_main();
        exp_valid = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end
    if (exp_valid) accept_main();
  endtask

  task automatic test_small_wrap;
    sq0 = '{100, 100, 100};
    sq1 = '{-50, -50, -50};
    drive_small();
    check_small("wrap3");
    checks++;
`ifdef ACC_SATURATE_EN
    if (s_out_data[7:0] !== 8'd127) begin failures++; $display("FAIL wrap3_plan got=%0d exp=127", $signed(s_out_data[7:0])); end
`else
    if (s_out_data[7:0] !== 8'd44) begin failures++; $display("FAIL wrap3_plan got=%0d exp=44", $signed(s_out_data[7:0])); end
`endif
    accept_small();
    for (int w = 0; w < 6; w++) begin
      int k;
      k = $urandom_range(1, 5);
      sq0.delete(); sq1.delete();
      for (int i = 0; i < k; i++) begin
        sq0.push_back(int'($urandom_range(0, 255)) - 128);
        sq1.push_back(int'($urandom_range(0, 255)) - 128);
      end
      drive_small();
      check_small($sformatf("srnd%0d", w));
      accept_small();
    end
  endtask

  task automatic test_count_sat;
    sq0 = '{1, 1, 1, 1, 1, 1};
    sq1 = '{-1, -1, -1, -1, -1, -1};
    drive_small();
    check_small("cnt6");
    accept_small();
    sq0 = '{1, 1, 1, 1, 1, 1, 1};
    sq1 = '{2, 2, 2, 2, 2, 2, 2};
    drive_small();
    check_small("cnt7");
    accept_small();
    sq0 = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    sq1 = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    drive_small();
    check_small("cnt10");
    accept_small();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_overrun();
    test_coincident();
    test_reset_mid();
    test_random();
    test_small_wrap();
    test_count_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
